// File: rtl/stepper_sequencer.sv
// Command-driven stepper phase generator: walks the 8-entry half-step table
// forward or backward by a commanded number of dot lines at a fixed step rate.
//
// state | meaning
// IDLE  | waiting for a command; phases hold (or drop) at current index
// RUN   | stepping every period clocks until target lines reached or abort
// DONE  | one-cycle completion pulse, then back to IDLE
module stepper_sequencer #(
  parameter int LINE_WIDTH   = 16,
  parameter int PERIOD_WIDTH = 16,
  parameter bit HOLD_ON_IDLE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_reverse,
  input  logic                    cmd_full_step,
  input  logic [LINE_WIDTH-1:0]   cmd_lines,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic                    abort,
  output logic                    motor_phase_a,
  output logic                    motor_phase_b,
  output logic                    motor_phase_na,
  output logic                    motor_phase_nb,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [LINE_WIDTH-1:0]   lines_done,
  output logic [2:0]              step_index
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    rev_q, full_q;
  logic [LINE_WIDTH-1:0]   lines_q;
  logic [PERIOD_WIDTH-1:0] period_q, timer;
  logic [1:0]              unit_cnt;
  logic                    accept, step_now, abort_now;
  logic [2:0]              step_units, unit_sum;
  logic                    line_wrap;
  logic [PERIOD_WIDTH-1:0] period_eff;

  assign step_units = full_q ? 3'd2 : 3'd1;
  assign unit_sum   = {1'b0, unit_cnt} + step_units;
  assign line_wrap  = unit_sum[2];
  // A zero period would never let the timer expire sensibly; run it as one clock.
  assign period_eff = (cmd_period == '0) ? PERIOD_WIDTH'(1) : cmd_period;

  // Next-state and handshake decode; abort beats a step due in the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_now  = 1'b0;
    abort_now = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !abort;
        if (cmd_valid && !abort) begin
          accept    = 1'b1;
          state_nxt = (cmd_lines == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          abort_now = 1'b1;
          state_nxt = DONE;
        end else if (timer == '0) begin
          step_now = 1'b1;
          if (line_wrap && (lines_done + LINE_WIDTH'(1) == lines_q))
            state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Command latch, step timer, index and line bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rev_q      <= 1'b0;
      full_q     <= 1'b0;
      lines_q    <= '0;
      period_q   <= PERIOD_WIDTH'(1);
      timer      <= '0;
      unit_cnt   <= 2'd0;
      lines_done <= '0;
      step_index <= 3'd0;
      aborted    <= 1'b0;
    end else begin
      if (accept) begin
        rev_q      <= cmd_reverse;
        full_q     <= cmd_full_step;
        lines_q    <= cmd_lines;
        period_q   <= period_eff;
        timer      <= period_eff - PERIOD_WIDTH'(1);
        unit_cnt   <= 2'd0;
        lines_done <= '0;
        aborted    <= 1'b0;
      end else if (abort_now) begin
        aborted <= 1'b1;
      end else if (step_now) begin
        timer      <= period_q - PERIOD_WIDTH'(1);
        step_index <= rev_q ? step_index - step_units : step_index + step_units;
        unit_cnt   <= unit_sum[1:0];
        if (line_wrap && lines_done != lines_q)
          lines_done <= lines_done + LINE_WIDTH'(1);
      end else if (state == RUN) begin
        timer <= timer - PERIOD_WIDTH'(1);
      end
    end
  end

  // Phase decode from the registered index only.
  always_comb begin
    logic [3:0] pat;
    unique case (step_index)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    if (!HOLD_ON_IDLE && state != RUN) pat = 4'b0000;
    {motor_phase_a, motor_phase_b, motor_phase_na, motor_phase_nb} = pat;
  end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: timing, direction, full/half step,
// zero-length moves, abort priority, command holding and mid-move reset.
module tb_stepper_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_reverse, cmd_full_step, abort;
  logic [15:0] cmd_lines, cmd_period, lines_done;
  logic        pa, pb, pna, pnb, busy, done, aborted;
  logic [2:0]  step_index;
  logic [3:0]  ph;

  int errors = 0;
  int checks = 0;
  int exp_idx;
  bit seen_done;

  assign ph = {pa, pb, pna, pnb};

  stepper_sequencer #(.LINE_WIDTH(16), .PERIOD_WIDTH(16), .HOLD_ON_IDLE(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reverse(cmd_reverse), .cmd_full_step(cmd_full_step),
    .cmd_lines(cmd_lines), .cmd_period(cmd_period), .abort(abort),
    .motor_phase_a(pa), .motor_phase_b(pb), .motor_phase_na(pna), .motor_phase_nb(pnb),
    .busy(busy), .done(done), .aborted(aborted), .lines_done(lines_done),
    .step_index(step_index)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int idx);
    case (idx % 8)
      0: return 4'b1000;
      1: return 4'b1100;
      2: return 4'b0100;
      3: return 4'b0110;
      4: return 4'b0010;
      5: return 4'b0011;
      6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rev, input logic full, input int lines, input int period);
    cmd_reverse   = rev;
    cmd_full_step = full;
    cmd_lines     = 16'(lines);
    cmd_period    = 16'(period);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_reverse = 1'b0; cmd_full_step = 1'b0;
    cmd_lines = '0; cmd_period = '0; abort = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);

    // reset state
    check("rst_phases", ph, 4'b1000);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_index", step_index, 0);
    check("rst_lines", lines_done, 0);

    // advance, half-step, 2 lines, period 5
    exp_idx = 0;
    issue(1'b0, 1'b0, 2, 5);
    check("adv_busy_start", busy, 1);
    for (int s = 1; s <= 8; s++) begin
      for (int c = 1; c <= 5; c++) begin
        tick(1);
        if (c == 5) begin
          exp_idx = (exp_idx + 1) % 8;
          check("adv_lines", lines_done, 32'(s / 4));
          check("adv_busy", busy, (s < 8) ? 1 : 0);
        end
        check("adv_index", step_index, 32'(exp_idx));
        check("adv_phase", ph, pat(exp_idx));
      end
    end
    check("adv_done", done, 1);
    check("adv_aborted", aborted, 0);
    tick(1);
    check("adv_done_clear", done, 0);
    check("adv_ready_idle", cmd_ready, 1);
    check("adv_hold_phase", ph, 4'b1000);

    // reverse, full-step, 3 lines, period 1, from index 0
    issue(1'b1, 1'b1, 3, 1);
    for (int s = 1; s <= 6; s++) begin
      tick(1);
      exp_idx = (exp_idx + 6) % 8;
      check("rev_index", step_index, 32'(exp_idx));
      check("rev_phase", ph, pat(exp_idx));
      check("rev_lines", lines_done, 32'(s / 2));
      check("rev_done", done, (s == 6) ? 1 : 0);
    end
    check("rev_final_index", step_index, 4);
    tick(1);

    // zero-line command with zero period
    issue(1'b0, 1'b0, 0, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_index", step_index, 4);
    check("zero_lines", lines_done, 0);
    tick(1);
    check("zero_done_clear", done, 0);
    check("zero_busy_after", busy, 0);
    check("zero_phase", ph, pat(4));

    // abort on a cycle where a step is due: rehome by reset first
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick(1);
    check("rehome_index", step_index, 0);
    issue(1'b0, 1'b0, 10, 4);
    tick(24);
    check("ab_index_pre", step_index, 6);
    check("ab_lines_pre", lines_done, 1);
    tick(3);
    abort = 1'b1;
    check("ab_ready_run", cmd_ready, 0);
    tick(1);
    abort = 1'b0;
    check("ab_done", done, 1);
    check("ab_aborted", aborted, 1);
    check("ab_index", step_index, 6);
    check("ab_lines", lines_done, 1);
    check("ab_busy", busy, 0);
    check("ab_phase", ph, pat(6));
    tick(1);
    check("ab_done_clear", done, 0);
    check("ab_aborted_hold", aborted, 1);

    // abort in IDLE is ignored apart from blocking ready
    abort = 1'b1;
    #1;
    check("idle_abort_ready", cmd_ready, 0);
    tick(2);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);
    check("idle_abort_index", step_index, 6);
    abort = 1'b0;
    tick(1);

    // cmd_valid held high through RUN and DONE
    cmd_reverse = 1'b0; cmd_full_step = 1'b0; cmd_lines = 16'd1; cmd_period = 16'd2;
    cmd_valid = 1'b1;
    tick(1);
    check("hold_aborted_clr", aborted, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("hold_ready", cmd_ready, 0);
      check("hold_busy", busy, (k < 8) ? 1 : 0);
    end
    check("hold_done", done, 1);
    check("hold_index", step_index, 2);
    check("hold_lines", lines_done, 1);
    tick(1);
    check("hold_idle_ready", cmd_ready, 1);
    check("hold_idle_busy", busy, 0);
    tick(1);
    check("hold_reaccept", busy, 1);
    tick(2);
    check("hold_second_step", step_index, 3);

    // reset pulsed mid-move
    tick(1);
    reset = 1'b0;
    #1;
    check("mid_rst_index", step_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_lines", lines_done, 0);
    check("mid_rst_phase", ph, 4'b1000);
    cmd_valid = 1'b0;
    tick(1);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (done || busy) seen_done = 1'b1;
    end
    check("mid_rst_no_done", seen_done, 0);
    check("mid_rst_index_hold", step_index, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
Command-driven stepper phase generator that drives the four print-mechanism motor phases (A, B, nA, nB) through the 8-entry half-step sequence.
- Advances or reverses the paper by a commanded number of dot lines at a programmable step rate, in half-step or full-step mode.
- Acts as the stimulus and controller for the stepper_motor decoder path: a self-test loopback and a bench-drive source for the analyser.

Parameters:
LINE_WIDTH, 16, width of line count command and lines_done counter
PERIOD_WIDTH, 16, width of step period (clock cycles per step)
HOLD_ON_IDLE, 1, 1 = phases stay energised at current index when idle; 0 = all phases low when idle

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accept; transfer when cmd_valid && cmd_ready
cmd_reverse  input  1  0 = advance (index +), 1 = reverse (index -)
cmd_full_step  input  1  1 = full-step (index ±2), 0 = half-step (index ±1)
cmd_lines  input  LINE_WIDTH  dot lines to move
cmd_period  input  PERIOD_WIDTH  clocks per step; 0 treated as 1
abort  input  1  stop current move
motor_phase_a  output  1  phase A drive
motor_phase_b  output  1  phase B drive
motor_phase_na  output  1  phase nA drive
motor_phase_nb  output  1  phase nB drive
busy  output  1  move in progress
done  output  1  1-cycle pulse at end of every accepted command
aborted  output  1  valid with done; 1 = move ended by abort
lines_done  output  LINE_WIDTH  lines completed in current or last move
step_index  output  3  current sequence index

Behaviour:
- Sequence table, index→asserted phases: 0:A, 1:A+B, 2:B, 3:B+nA, 4:nA, 5:nA+nB, 6:nB, 7:nB+A. All other phases are low.
- Phases are decoded from the registered step_index, with no combinational path from inputs. If HOLD_ON_IDLE=0, phases are forced low in IDLE and DONE.
- Reset values:
  - state=IDLE, step_index=0, lines_done=0, unit_cnt=0.
  - busy=0, done=0, aborted=0.
  - cmd_ready=1 once reset deasserts.
  - Phases show the index-0 pattern (A only) if HOLD_ON_IDLE=1, else all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = !abort.
  - On transfer: latch reverse, full_step, lines, period (0→1); clear lines_done and unit_cnt; load timer = period-1.
  - If lines==0: go to DONE (no steps). Otherwise go to RUN.
  - abort in IDLE is ignored.
- RUN:
  - busy=1, cmd_ready=0, and cmd_valid is ignored.
  - Timer decrements each cycle.
  - When timer==0:
    - step_index += inc (inc = ±1 half-step, ±2 full-step), mod 8.
    - unit_cnt (2-bit) += |inc|.
    - On unit_cnt wrap (4 half-step units = 1 dot line), lines_done increments.
    - Timer reloads to period-1.
  - First step occurs exactly `period` cycles after the acceptance cycle; subsequent steps follow every `period` cycles.
  - When lines_done reaches the latched lines value, go to DONE. The final step's phase pattern is visible at the same time.
- Abort in RUN: takes priority over a step due in the same cycle (that step is not taken); go to DONE with aborted=1. step_index and lines_done hold their values.
- DONE:
  - Lasts 1 cycle: done=1, busy=0, cmd_ready=0.
  - aborted is held until the next command is accepted.
  - Returns to IDLE.
- Full-step from an even index drives single-coil steps (0,2,4,6); from an odd index it drives two-coil steps. No alignment is performed.
- step_index persists across commands and is never re-homed except by reset.
- lines_done saturates at the latched target and never wraps.
- Reset asserted mid-move: immediate return to reset values; no done pulse.

Test Plan:
- Reset, HOLD_ON_IDLE=1 → phases A=1, B=nA=nB=0; cmd_ready=1; busy=0.
- Advance, half-step, lines=2, period=5 → 8 steps 5 cycles apart (first step 5 cycles after accept); indices 1..7,0; done pulse with lines_done=2, aborted=0. Loopback through stepper_motor → exactly 2 line_advance_tick and no invalid_step.
- Reverse, full-step, lines=3, period=1, start index 0 → 6 consecutive single-cycle steps (6,4,2,0,6,4); lines_done=3; decoder gives 3 line_reverse_tick.
- lines=0, period=0 → no phase change; done on the cycle after accept; busy never asserts.
- Advance, half-step, lines=10, period=4; abort asserted on a cycle where timer==0 after step 6 → step 7 is not taken; step_index=6; lines_done=1; done=1 and aborted=1 one cycle later.
- cmd_valid held high during RUN and DONE → not accepted until IDLE. Reset pulsed mid-move → step_index=0, busy=0, and no done pulse.
